// File: rtl/mul_operand_feeder.sv
// rtl/mul_operand_feeder.sv - operand sequencer for the repeated-addition 16-bit multiplier
// 2-entry operand FIFO, A-then-B bus sequencing, zero bypass, done timeout and result stream.
`timescale 1ns/1ps
module mul_operand_feeder #(
  parameter int unsigned TIMEOUT = 65544
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [15:0] i_in_a,
  input  logic [15:0] i_in_b,
  output logic        o_mul_start,
  output logic [15:0] o_mul_data,
  output logic        o_mul_clr,
  input  logic        i_mul_done,
  input  logic [15:0] i_mul_product,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [15:0] o_res_data,
  output logic        o_res_err
);

  localparam logic [16:0] LAST_WAIT = 17'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SEND_A, S_SEND_B, S_WAIT, S_OUT
  } state_t;

  state_t      r_state;
  logic [15:0] r_fifo_a [2];
  logic [15:0] r_fifo_b [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [15:0] r_ra;
  logic [15:0] r_rb;
  logic [16:0] r_counter;
  logic        r_mul_start;
  logic [15:0] r_mul_data;
  logic        r_mul_clr;
  logic [15:0] r_res_data;
  logic        r_res_err;

  logic        w_push;
  logic        w_pop;
  logic [15:0] w_head_a;
  logic [15:0] w_head_b;

  assign o_in_ready  = (r_count != 2'd2);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != 2'd0);
  assign w_head_a    = r_fifo_a[r_rd_ptr];
  assign w_head_b    = r_fifo_b[r_rd_ptr];

  assign o_mul_start = r_mul_start;
  assign o_mul_data  = r_mul_data;
  assign o_mul_clr   = r_mul_clr;
  assign o_res_valid = (r_state == S_OUT);
  assign o_res_data  = r_res_data;
  assign o_res_err   = r_res_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_a[r_wr_ptr] <= i_in_a;
        r_fifo_b[r_wr_ptr] <= i_in_b;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Bus outputs are set on the transition into each state so they are valid for the whole state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ra        <= 16'd0;
      r_rb        <= 16'd0;
      r_counter   <= 17'd0;
      r_mul_start <= 1'b0;
      r_mul_data  <= 16'd0;
      r_mul_clr   <= 1'b0;
      r_res_data  <= 16'd0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_ra <= w_head_a;
            r_rb <= w_head_b;
            if ((w_head_a == 16'd0) || (w_head_b == 16'd0)) begin
              r_res_data <= 16'd0;
              r_res_err  <= 1'b0;
              r_state    <= S_OUT;
            end else begin
              r_mul_start <= 1'b1;
              r_mul_data  <= w_head_a;
              r_state     <= S_START;
            end
          end
        end
        S_START: begin
          r_mul_start <= 1'b0;
          r_state     <= S_SEND_A;
        end
        S_SEND_A: begin
          r_mul_data <= r_rb;
          r_state    <= S_SEND_B;
        end
        S_SEND_B: begin
          r_counter <= 17'd0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_counter <= r_counter + 17'd1;
          // done wins over an expiring timeout in the same cycle
          if (i_mul_done) begin
            r_res_data <= i_mul_product;
            r_res_err  <= 1'b0;
            r_mul_data <= 16'd0;
            r_mul_clr  <= 1'b1;
            r_state    <= S_OUT;
          end else if (r_counter == LAST_WAIT) begin
            r_res_data <= 16'd0;
            r_res_err  <= 1'b1;
            r_mul_data <= 16'd0;
            r_mul_clr  <= 1'b1;
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          r_mul_clr <= 1'b0;
          if (i_res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// tb/tb_mul_operand_feeder.sv - self-checking bench for mul_operand_feeder
// Bench-side multiplier model and in-order result scoreboard, plus directed literal checks.
`timescale 1ns/1ps
module tb_mul_operand_feeder;

  localparam int T = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        err;
    logic        byp;
    int          dd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_in_a;
  logic [15:0] i_in_b;
  logic        o_mul_start;
  logic [15:0] o_mul_data;
  logic        o_mul_clr;
  logic        i_mul_done;
  logic [15:0] i_mul_product;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [15:0] o_res_data;
  logic        o_res_err;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          dd = 6;
  bit          glitch = 1'b0;
  int          acc_cyc = 0;

  exp_t        exp_q[$];
  int          rv_cycles[$];
  logic [15:0] res_log_data[$];
  logic        res_log_err[$];
  logic [15:0] seq[3];
  bit          started = 1'b0;
  bit          rv_seen = 1'b0;
  int          s_cyc = 0;
  int          n_start = 0;
  int          n_clr = 0;

  mul_operand_feeder #(.TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_a(i_in_a), .i_in_b(i_in_b),
    .o_mul_start(o_mul_start), .o_mul_data(o_mul_data), .o_mul_clr(o_mul_clr),
    .i_mul_done(i_mul_done), .i_mul_product(i_mul_product),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_data(o_res_data), .o_res_err(o_res_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int d);
    exp_t        e;
    logic [31:0] p;
    p      = 32'(a) * 32'(b);
    e.a    = a;
    e.b    = b;
    e.dd   = d;
    e.byp  = (a == 16'd0) || (b == 16'd0);
    e.data = 16'd0;
    e.err  = 1'b0;
    if (!e.byp) begin
      if (d >= 0 && d < T) e.data = p[15:0];
      else e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic int waitlen(input int d);
    return (d >= 0 && d < T) ? d + 1 : T;
  endfunction

  // Scoreboard, protocol checks and multiplier model, all evaluated mid-cycle.
  always @(negedge clk) begin
    logic [31:0] p;
    i_mul_done    = 1'b0;
    i_mul_product = 16'h0000;
    if (rst) begin
      exp_q.delete();
      started = 1'b0;
      rv_seen = 1'b0;
    end else begin
      if (o_mul_start) begin
        n_start++;
        if (exp_q.size() == 0 || exp_q[0].byp || started) fail("start_unexpected");
        else begin
          started = 1'b1;
          s_cyc   = cyc;
        end
      end
      if (started && !o_res_valid && exp_q.size() != 0) begin
        if (cyc == s_cyc)          begin chk("bus_a_start", o_mul_data, exp_q[0].a); seq[0] = o_mul_data; end
        else if (cyc == s_cyc + 1) begin chk("bus_a_send",  o_mul_data, exp_q[0].a); seq[1] = o_mul_data; end
        else if (cyc == s_cyc + 2) begin chk("bus_b_send",  o_mul_data, exp_q[0].b); seq[2] = o_mul_data; end
        else                             chk("bus_b_wait",  o_mul_data, exp_q[0].b);
      end
      if (o_mul_clr) n_clr++;
      if (o_res_valid) begin
        if (exp_q.size() == 0) fail("res_unexpected");
        else begin
          if (!rv_seen) begin
            rv_seen = 1'b1;
            rv_cycles.push_back(cyc);
            chk("clr_first", o_mul_clr, !exp_q[0].byp);
            if (exp_q[0].byp) chk("bypass_nostart", started, 0);
            else chk("res_latency", cyc, s_cyc + 3 + waitlen(exp_q[0].dd));
          end else begin
            chk("clr_once", o_mul_clr, 0);
          end
          chk("res_data", o_res_data, exp_q[0].data);
          chk("res_err", o_res_err, exp_q[0].err);
          chk("bus_out_zero", o_mul_data, 0);
          if (i_res_ready) begin
            res_log_data.push_back(o_res_data);
            res_log_err.push_back(o_res_err);
            void'(exp_q.pop_front());
            started = 1'b0;
            rv_seen = 1'b0;
          end
        end
      end else if (o_mul_clr) begin
        fail("clr_outside_out");
      end
      if (started && !o_res_valid && exp_q.size() != 0) begin
        if (exp_q[0].dd >= 0 && cyc == s_cyc + 3 + exp_q[0].dd) begin
          p             = 32'(exp_q[0].a) * 32'(exp_q[0].b);
          i_mul_done    = 1'b1;
          i_mul_product = p[15:0];
        end else if (glitch && cyc == s_cyc + 1) begin
          i_mul_done    = 1'b1;
          i_mul_product = 16'hDEAD;
        end
      end
      if (i_in_valid && o_in_ready) exp_q.push_back(model(i_in_a, i_in_b, dd));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int k;
    k          = 0;
    i_in_valid = 1'b1;
    i_in_a     = a;
    i_in_b     = b;
    @(negedge clk);
    while (!o_in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!o_in_ready) fail("push_timeout");
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (exp_q.size() != 0) fail("drain_timeout");
    tick(1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  o_in_ready, 1);
    chk({tag, "_mul_start"}, o_mul_start, 0);
    chk({tag, "_mul_data"},  o_mul_data, 0);
    chk({tag, "_mul_clr"},   o_mul_clr, 0);
    chk({tag, "_res_valid"}, o_res_valid, 0);
    chk({tag, "_res_data"},  o_res_data, 0);
    chk({tag, "_res_err"},   o_res_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int a1;
    int st;
    int k;
    rst         = 1'b1;
    i_in_valid  = 1'b0;
    i_in_a      = 16'd0;
    i_in_b      = 16'd0;
    i_res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    tick(1);

    // (3,5), done on the 7th WAIT cycle, with a stray done during SEND_A
    dd = 6; glitch = 1'b1;
    push(16'd3, 16'd5);
    drain();
    glitch = 1'b0;
    chk("t1_product", res_log_data[0], 16'd15);
    chk("t1_err", res_log_err[0], 0);
    chk("t1_starts", n_start, 1);
    chk("t1_clr", n_clr, 1);
    chk("t1_seq0", seq[0], 16'd3);
    chk("t1_seq1", seq[1], 16'd3);
    chk("t1_seq2", seq[2], 16'd5);

    // zero-operand bypass
    base = rv_cycles.size();
    push(16'd0, 16'd1234);
    a1 = acc_cyc;
    push(16'd1234, 16'd0);
    drain();
    chk("t2_lat0", rv_cycles[base], a1 + 2);
    chk("t2_lat1", rv_cycles[base + 1], a1 + 4);
    chk("t2_data", res_log_data[base + 1], 16'd0);
    chk("t2_nostart", n_start, 1);

    // backpressure: 1 working + 2 queued, 4th blocked
    dd = 2; i_res_ready = 1'b0;
    base = res_log_data.size();
    push(16'd2, 16'd3);
    push(16'd4, 16'd5);
    push(16'd6, 16'd7);
    i_in_valid = 1'b1; i_in_a = 16'd8; i_in_b = 16'd9;
    tick(30);
    @(negedge clk);
    chk("t3_full_ready", o_in_ready, 0);
    chk("t3_res_held", o_res_valid, 1);
    @(posedge clk);
    #1 i_res_ready = 1'b1;
    push(16'd8, 16'd9);
    drain();
    chk("t3_count", res_log_data.size(), base + 4);
    chk("t3_last", res_log_data[base + 3], 16'd72);

    // timeout, then a normal pair
    base = res_log_data.size();
    dd = -1;
    push(16'd5, 16'd5);
    dd = 2;
    push(16'd3, 16'd4);
    drain();
    chk("t4_to_err", res_log_err[base], 1);
    chk("t4_to_data", res_log_data[base], 16'd0);
    chk("t4_next", res_log_data[base + 1], 16'd12);

    // done coinciding with the last WAIT cycle; 16-bit truncation
    base = res_log_data.size();
    dd = T - 1;
    push(16'd100, 16'd7);
    dd = 3;
    push(16'd300, 16'd300);
    drain();
    chk("t5_tie_data", res_log_data[base], 16'd700);
    chk("t5_tie_err", res_log_err[base], 0);
    chk("t5_trunc", res_log_data[base + 1], 16'd24464);

    // reset during WAIT with one pair queued
    dd = -1;
    push(16'd7, 16'd9);
    push(16'd2, 16'd2);
    k = 0;
    @(negedge clk);
    while (!o_mul_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!o_mul_start) fail("t6_no_start");
    tick(4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("t6_rst");
    base = res_log_data.size();
    st   = n_start;
    tick(40);
    chk("t6_no_start_after", n_start, st);
    chk("t6_no_result", res_log_data.size(), base);
    dd = 3;
    push(16'd6, 16'd7);
    drain();
    chk("t6_recover", res_log_data[base], 16'd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
